// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback and drives datapath controls.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles with memready_i tied high; outputs are combinational from state.
// Backpressure: FETCH, MEMRD and MEMWR hold until memready_i; a stall of TIMEOUT cycles (if nonzero) traps to ERR.
//
// Ports:
//   clk_i, reset_i        : clock and synchronous active-high reset
//   op_i, funct_i         : instr[31:26] and instr[5:0] from the instruction register
//   zero_i                : ALU zero flag (qualifies the beq PC write)
//   memready_i            : shared memory port completes the current access this cycle
//   pcen_o .. pcsrc_o     : datapath enables, strobes and mux selects
//   alucontrol_o          : ALU operation code
//   state_o, err_o        : debug state and sticky error flag
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       memready_i,
  output logic       pcen_o,
  output logic       iord_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsrc_o,
  output logic [2:0] alucontrol_o,
  output logic [3:0] state_o,
  output logic       err_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_ERR     = 4'd15
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Stall counter only needs to reach TIMEOUT.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            waiting;
  logic            timeout_hit;
  logic            funct_ok;
  logic [2:0]      funct_alu;

  // Datapath controls before reset gating.
  logic            pcwrite;
  logic            branch;
  logic            irwrite;
  logic            memwrite;
  logic            regwrite;
  aluop_e          aluop;

  // R-type function decode; unknown functs fall back to add and flag illegal.
  always_comb begin
    funct_alu = 3'b010;
    funct_ok  = 1'b1;
    case (funct_i)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // A memory-facing state that is still waiting on the memory this cycle.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) && !memready_i;

  // The trap fires on the stalled cycle that brings the count to TIMEOUT;
  // memready_i high on that cycle clears waiting, so completion wins.
  assign timeout_hit = (TIMEOUT != 0) && waiting && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (memready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_ERR;
        endcase
      end
      S_MEMADR:  state_d = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (memready_i) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (memready_i) state_d = S_FETCH;
      S_RTYPEEX: state_d = funct_ok ? S_RTYPEWB : S_ERR;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_ERR;
    endcase
    if (timeout_hit) state_d = S_ERR;
  end

  // Counter runs only across consecutive stalled cycles of the same state.
  assign cnt_d = (waiting && (state_d == state_q)) ? cnt_q + CW'(1) : '0;
  assign err_d = err_q | (state_d == S_ERR);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from the current state.
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    iord_o     = 1'b0;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = 2'b00;
    pcsrc_o    = 2'b00;
    aluop      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb_o = 2'b01;
        pcwrite   = memready_i;
        irwrite   = memready_i;
      end
      S_DECODE:  alusrcb_o = 2'b11;
      S_MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
      end
      S_MEMRD:   iord_o = 1'b1;
      S_MEMWB: begin
        memtoreg_o = 1'b1;
        regwrite   = 1'b1;
      end
      S_MEMWR: begin
        iord_o   = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_o = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst_o = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca_o = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_o   = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX: begin
        pcsrc_o = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol_o = 3'b010;
    case (aluop)
      ALUOP_SUB:   alucontrol_o = 3'b110;
      ALUOP_FUNCT: alucontrol_o = funct_alu;
      default:     alucontrol_o = 3'b010;
    endcase
  end

  // Reset suppresses every write so an interrupted instruction leaves no partial update.
  assign pcen_o     = !reset_i && (pcwrite || (branch && zero_i));
  assign irwrite_o  = !reset_i && irwrite;
  assign memwrite_o = !reset_i && memwrite;
  assign regwrite_o = !reset_i && regwrite;

  assign state_o = state_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7,
                         BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11, ERR = 4'd15;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;

  // Per-state membership sets, bit n = state n.
  localparam logic [15:0] SET_IORD     = 16'h0028; // MEMRD, MEMWR
  localparam logic [15:0] SET_ALUSRCA  = 16'h0344; // MEMADR, RTYPEEX, BEQEX, ADDIEX
  localparam logic [15:0] SET_REGWRITE = 16'h0490; // MEMWB, RTYPEWB, ADDIWB
  localparam logic [15:0] SET_ALUADD   = 16'h0207; // FETCH, DECODE, MEMADR, ADDIEX

  logic       clk, reset, zero, memready;
  logic [5:0] op, funct;
  logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  mips_multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .op_i(op), .funct_i(funct), .zero_i(zero),
    .memready_i(memready), .pcen_o(pcen), .iord_o(iord), .memwrite_o(memwrite),
    .irwrite_o(irwrite), .regwrite_o(regwrite), .regdst_o(regdst), .memtoreg_o(memtoreg),
    .alusrca_o(alusrca), .alusrcb_o(alusrcb), .pcsrc_o(pcsrc), .alucontrol_o(alucontrol),
    .state_o(state), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       mr;
    logic       z;
    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] st;
    logic       err;
  } vec_t;

  vec_t       vq[$];
  logic [5:0] g_op, g_funct;
  int         checks = 0;
  int         passed = 0;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, input logic mr, input logic z, input logic [3:0] st, input logic e);
    vec_t v;
    v.rst = rst; v.mr = mr; v.z = z; v.op = g_op; v.funct = g_funct; v.st = st; v.err = e;
    vq.push_back(v);
  endtask

  // ALU code for an R-type funct; ok=0 for functs the controller must reject.
  function automatic logic [2:0] funct_code(input logic [5:0] f, output logic ok);
    ok = 1'b1;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin ok = 1'b0; return 3'b010; end
    endcase
  endfunction

  // n cycles parked in ERR, then one reset cycle that returns to FETCH.
  task automatic err_tail(input int n);
    repeat (n) push(1'b0, rnd(), rnd(), ERR, 1'b1);
    push(1'b1, rnd(), rnd(), ERR, 1'b1);
  endtask

  // A memory-facing state stalled for `stall` cycles; TO or more stalls trap.
  task automatic mem_wait(input logic [3:0] st, input int stall, output bit died);
    died = 1'b0;
    for (int i = 0; i < stall && i < TO; i++) push(1'b0, 1'b0, rnd(), st, 1'b0);
    if (stall >= TO) begin
      died = 1'b1;
      err_tail(3);
    end else begin
      push(1'b0, 1'b1, rnd(), st, 1'b0);
    end
  endtask

  // Expected cycle trace of one instruction, from the instruction-level rules.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fst, input int mst, input logic z);
    bit   died;
    logic ok;
    logic [2:0] unused_code;
    g_op = o; g_funct = f;
    mem_wait(FETCH, fst, died);
    if (died) return;
    push(1'b0, rnd(), rnd(), DECODE, 1'b0);
    case (o)
      OP_LW: begin
        push(1'b0, rnd(), rnd(), MEMADR, 1'b0);
        mem_wait(MEMRD, mst, died);
        if (!died) push(1'b0, rnd(), rnd(), MEMWB, 1'b0);
      end
      OP_SW: begin
        push(1'b0, rnd(), rnd(), MEMADR, 1'b0);
        mem_wait(MEMWR, mst, died);
      end
      OP_R: begin
        push(1'b0, rnd(), rnd(), RTYPEEX, 1'b0);
        unused_code = funct_code(f, ok);
        if (ok) push(1'b0, rnd(), rnd(), RTYPEWB, 1'b0);
        else    err_tail(3);
      end
      OP_BEQ: push(1'b0, rnd(), z, BEQEX, 1'b0);
      OP_ADDI: begin
        push(1'b0, rnd(), rnd(), ADDIEX, 1'b0);
        push(1'b0, rnd(), rnd(), ADDIWB, 1'b0);
      end
      OP_J: push(1'b0, rnd(), rnd(), JEX, 1'b0);
      default: err_tail(10);
    endcase
  endtask

  // Packed as {state, err, pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
  //            alusrca, alusrcb, pcsrc, alucontrol}; mask hides alucontrol where undefined.
  function automatic logic [19:0] expected(input vec_t v, output logic [19:0] mask);
    logic       live, ok, e_pcen;
    logic [1:0] e_srcb, e_pcsrc;
    logic [2:0] e_alu;
    live  = !v.rst;
    mask  = 20'hFFFFF;
    e_alu = 3'b010;
    if (SET_ALUADD[v.st])   e_alu = 3'b010;
    else if (v.st == BEQEX) e_alu = 3'b110;
    else if (v.st == RTYPEEX) e_alu = funct_code(v.funct, ok);
    else mask[2:0] = 3'b000;
    e_srcb  = (v.st == FETCH) ? 2'b01 : (v.st == DECODE) ? 2'b11 :
              (v.st == MEMADR || v.st == ADDIEX) ? 2'b10 : 2'b00;
    e_pcsrc = (v.st == BEQEX) ? 2'b01 : (v.st == JEX) ? 2'b10 : 2'b00;
    e_pcen  = (v.st == FETCH && v.mr) || (v.st == JEX) || (v.st == BEQEX && v.z);
    return {v.st, v.err,
            live & e_pcen,
            SET_IORD[v.st],
            live & (v.st == MEMWR),
            live & (v.st == FETCH) & v.mr,
            live & SET_REGWRITE[v.st],
            (v.st == RTYPEWB),
            (v.st == MEMWB),
            SET_ALUSRCA[v.st],
            e_srcb, e_pcsrc, e_alu};
  endfunction

  function automatic int pick_stall();
    int r;
    r = $urandom_range(0, 15);
    return (r == 0) ? TO : (r % 4);
  endfunction

  initial begin
    logic [19:0] exp_v, mask, act;
    logic [5:0]  rops[7];
    logic [5:0]  rfun[6];
    rops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J, 6'b111111};
    rfun = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};

    reset = 1'b1; memready = 1'b1; zero = 1'b0; op = '0; funct = '0;
    g_op = '0; g_funct = '0;
    @(negedge clk);

    checks++;
    if (state == FETCH && err == 1'b0 && !pcen && !irwrite && !memwrite && !regwrite) passed++;
    else $display("FAIL reset state: state=%0d err=%b pcen=%b irwrite=%b memwrite=%b regwrite=%b",
                  state, err, pcen, irwrite, memwrite, regwrite);

    // Reset state while reset is still held.
    push(1'b1, 1'b1, 1'b0, FETCH, 1'b0);
    push(1'b1, 1'b1, 1'b0, FETCH, 1'b0);
    // Directed instruction scenarios.
    run_instr(OP_ADDI, 6'b000000, 0, 0, 1'b0);
    run_instr(OP_LW,   6'b000000, 0, 2, 1'b0);
    run_instr(OP_SW,   6'b000000, 0, 2, 1'b0);
    run_instr(OP_R,    6'b101010, 0, 0, 1'b0);
    run_instr(OP_BEQ,  6'b000000, 0, 0, 1'b1);
    run_instr(OP_BEQ,  6'b000000, 0, 0, 1'b0);
    run_instr(OP_J,    6'b000000, 1, 0, 1'b0);
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);
    run_instr(OP_ADDI, 6'b000000, TO, 0, 1'b0);     // fetch timeout
    run_instr(OP_ADDI, 6'b000000, TO - 1, 0, 1'b0); // memready on the deciding cycle
    run_instr(OP_SW,   6'b000000, 0, TO, 1'b0);     // write timeout
    run_instr(OP_LW,   6'b000000, 0, TO, 1'b0);     // read timeout
    run_instr(OP_R,    6'b000111, 0, 0, 1'b0);      // illegal funct
    // Reset landing in MEMWR must suppress the write strobe.
    g_op = OP_SW; g_funct = '0;
    push(1'b0, 1'b1, 1'b0, FETCH, 1'b0);
    push(1'b0, 1'b0, 1'b0, DECODE, 1'b0);
    push(1'b0, 1'b0, 1'b0, MEMADR, 1'b0);
    push(1'b1, 1'b0, 1'b0, MEMWR, 1'b0);
    run_instr(OP_ADDI, 6'b000000, 0, 0, 1'b0);
    // Random instruction stream.
    for (int n = 0; n < 80; n++) begin
      int k;
      k = ($urandom_range(0, 19) == 0) ? 6 : $urandom_range(0, 5);
      run_instr(rops[k], rfun[$urandom_range(0, 5)], pick_stall(), pick_stall(), rnd());
    end

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; memready = vq[i].mr; zero = vq[i].z;
      op = vq[i].op; funct = vq[i].funct;
      #1;
      exp_v = expected(vq[i], mask);
      act = {state, err, pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
             alusrca, alusrcb, pcsrc, alucontrol};
      checks++;
      if (((act ^ exp_v) & mask) == 20'h0) passed++;
      else $display("FAIL cycle%0d op=%b exp_state=%0d: got %h want %h (mask %h)",
                    i, vq[i].op, vq[i].st, act, exp_v, mask);
      if (!vq[i].rst && vq[i].st == ERR) begin
        checks++;
        if (state == ERR && err == 1'b1 && !pcen && !irwrite && !memwrite && !regwrite) passed++;
        else $display("FAIL cycle%0d expired/illegal: state=%0d err=%b pcen=%b irwrite=%b memwrite=%b regwrite=%b",
                      i, state, err, pcen, irwrite, memwrite, regwrite);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
